mod_n_counter: RTL and testbench

Parametrised, cascadable modulo-N counter. Generalises the fixed 0–59 seconds counter to any modulus and width. Adds up/down counting, synchronous clear, range-checked parallel load, compare match and a sticky wrap flag. Chained instances form seconds/minutes/hours timers and countdown timers: one instance's `carry_out` drives the next instance's `enable`.

---
 rtl/mod_n_counter.sv | 96 +++++++++
 tb/tb_mod_n_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_counter.sv
// Cascadable modulo-N up/down counter with synchronous clear, range-checked load,
// compare match, sticky wrap flag and a combinational carry-out for chaining.
module mod_n_counter #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned MODULUS = 60,
  parameter int unsigned INIT    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             up_down_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic [WIDTH-1:0] compare_value_i,
  output logic [WIDTH-1:0] count_o,
  output logic             carry_out_o,
  output logic             match_o,
  output logic             wrapped_o,
  output logic             load_err_o
);

  if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 || MODULUS > (32'd1 << WIDTH) ||
      INIT >= MODULUS) begin : gen_bad_params
    $error("mod_n_counter: illegal WIDTH/MODULUS/INIT combination");
  end

  // One extra bit so MODULUS == 2**WIDTH is representable for the load range check.
  localparam logic [WIDTH:0]   ModExt  = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] InitVal = WIDTH'(INIT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic             load_err_q, load_err_d;

  logic [WIDTH-1:0] tc;
  logic [WIDTH-1:0] step_val;
  logic             at_tc;
  logic             load_ok;

  always_comb begin
    tc      = up_down_i ? MaxVal : '0;
    at_tc   = (count_q == tc);
    load_ok = ({1'b0, load_value_i} < ModExt);
    // Wrap is always an explicit compare, never the natural WIDTH-bit overflow.
    if (at_tc) begin
      step_val = up_down_i ? '0 : MaxVal;
    end else if (up_down_i) begin
      step_val = count_q + WIDTH'(1);
    end else begin
      step_val = count_q - WIDTH'(1);
    end
  end

  always_comb begin
    count_d    = count_q;
    wrapped_d  = wrapped_q;
    load_err_d = 1'b0;
    if (clear_i) begin
      count_d   = '0;
      wrapped_d = 1'b0;
    end else if (load_i) begin
      if (load_ok) begin
        count_d = load_value_i;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (enable_i) begin
      count_d = step_val;
      if (at_tc) begin
        wrapped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= InitVal;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrapped_q  <= wrapped_d;
      load_err_q <= load_err_d;
    end
  end

  assign count_o     = count_q;
  assign wrapped_o   = wrapped_q;
  assign load_err_o  = load_err_q;
  // Asserted in the cycle before the wrap edge so the next stage steps on that same edge.
  assign carry_out_o = enable_i & ~clear_i & ~load_i & at_tc;
  assign match_o     = (count_q == compare_value_i);

endmodule

// File: tb/tb_mod_n_counter.sv
// Scoreboard bench for mod_n_counter: directed stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_mod_n_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear, enable, up_down, load;
  logic [5:0] load_value, compare_value;
  logic [5:0] count;
  logic       carry_out, match, wrapped, load_err;

  logic       cas_clr;
  logic [5:0] lo_count, hi_count;
  logic       lo_carry, hi_carry, lo_match, hi_match, lo_wr, hi_wr, lo_le, hi_le;

  logic       m_ld, m_en;
  logic [5:0] m_ldv;
  logic [5:0] m_count;
  logic       m_carry, m_match, m_wr, m_le;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod_n_counter u_dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .enable_i(enable), .up_down_i(up_down),
    .load_i(load), .load_value_i(load_value), .compare_value_i(compare_value),
    .count_o(count), .carry_out_o(carry_out), .match_o(match), .wrapped_o(wrapped),
    .load_err_o(load_err)
  );

  mod_n_counter u_lo (
    .clk(clk), .rst_n(rst_n), .clear_i(cas_clr), .enable_i(1'b1), .up_down_i(1'b1),
    .load_i(1'b0), .load_value_i(6'd0), .compare_value_i(6'd0),
    .count_o(lo_count), .carry_out_o(lo_carry), .match_o(lo_match), .wrapped_o(lo_wr),
    .load_err_o(lo_le)
  );

  mod_n_counter u_hi (
    .clk(clk), .rst_n(rst_n), .clear_i(cas_clr), .enable_i(lo_carry), .up_down_i(1'b1),
    .load_i(1'b0), .load_value_i(6'd0), .compare_value_i(6'd0),
    .count_o(hi_count), .carry_out_o(hi_carry), .match_o(hi_match), .wrapped_o(hi_wr),
    .load_err_o(hi_le)
  );

  mod_n_counter #(.WIDTH(6), .MODULUS(64), .INIT(0)) u_m64 (
    .clk(clk), .rst_n(rst_n), .clear_i(1'b0), .enable_i(m_en), .up_down_i(1'b1),
    .load_i(m_ld), .load_value_i(m_ldv), .compare_value_i(6'd0),
    .count_o(m_count), .carry_out_o(m_carry), .match_o(m_match), .wrapped_o(m_wr),
    .load_err_o(m_le)
  );

  // tgt: 0 = main counter, 1 = 60->60 cascade, 2 = modulus-64 counter
  typedef struct {
    string       nm;
    int unsigned tgt;
    logic [5:0]  cnt;
    logic        cy;
    logic        mt;
    logic        wr;
    logic        le;
    logic [5:0]  cnt2;
  } exp_t;

  exp_t sb[$];

  task automatic push(input string nm, input int unsigned tgt, input logic [5:0] c,
                      input logic cy, input logic mt, input logic wr, input logic le,
                      input logic [5:0] c2);
    exp_t e;
    e.nm = nm; e.tgt = tgt; e.cnt = c; e.cy = cy; e.mt = mt; e.wr = wr; e.le = le;
    e.cnt2 = c2;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.tgt)
          0: begin
            chk({e.nm, ".count"}, {1'b0, count}, {1'b0, e.cnt});
            chk({e.nm, ".carry"}, {6'd0, carry_out}, {6'd0, e.cy});
            chk({e.nm, ".match"}, {6'd0, match}, {6'd0, e.mt});
            chk({e.nm, ".wrapped"}, {6'd0, wrapped}, {6'd0, e.wr});
            chk({e.nm, ".load_err"}, {6'd0, load_err}, {6'd0, e.le});
          end
          1: begin
            chk({e.nm, ".lo"}, {1'b0, lo_count}, {1'b0, e.cnt});
            chk({e.nm, ".lo_carry"}, {6'd0, lo_carry}, {6'd0, e.cy});
            chk({e.nm, ".hi"}, {1'b0, hi_count}, {1'b0, e.cnt2});
            chk({e.nm, ".hi_carry"}, {6'd0, hi_carry}, 7'd0);
            chk({e.nm, ".lo_le"}, {6'd0, lo_le}, 7'd0);
          end
          default: begin
            chk({e.nm, ".count"}, {1'b0, m_count}, {1'b0, e.cnt});
            chk({e.nm, ".carry"}, {6'd0, m_carry}, {6'd0, e.cy});
            chk({e.nm, ".wrapped"}, {6'd0, m_wr}, {6'd0, e.wr});
          end
        endcase
      end
    end
  end

  // Drive main inputs after a posedge, then queue what this cycle should show.
  task automatic m(input string nm, input logic clr, input logic en, input logic ud,
                   input logic ld, input logic [5:0] ldv, input logic [5:0] c,
                   input logic cy, input logic mt, input logic wr, input logic le);
    @(posedge clk); #1;
    clear = clr; enable = en; up_down = ud; load = ld; load_value = ldv;
    push(nm, 0, c, cy, mt, wr, le, 6'd0);
  endtask

  task automatic m64(input string nm, input logic ld, input logic [5:0] ldv, input logic en,
                     input logic [5:0] c, input logic cy, input logic wr);
    @(posedge clk); #1;
    m_ld = ld; m_ldv = ldv; m_en = en;
    push(nm, 2, c, cy, 1'b0, wr, 1'b0, 6'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0; clear = 1'b0; enable = 1'b0; up_down = 1'b1; load = 1'b0;
    load_value = '0; compare_value = 6'd30; cas_clr = 1'b0;
    m_ld = 1'b0; m_ldv = '0; m_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    //  name         clr en ud ld ldv   cnt cy mt wr le
    m("cnt0",        0, 1, 1, 0, 0,    0,  0, 0, 0, 0);
    m("cnt1",        0, 1, 1, 0, 0,    1,  0, 0, 0, 0);
    m("cnt2",        0, 1, 1, 0, 0,    2,  0, 0, 0, 0);
    m("pre_rst",     0, 0, 1, 0, 0,    3,  0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    push("async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push("hold", 0, 0, 0, 0, 0, 0, 0);
    repeat (4) m("hold", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // up wrap
    m("ld58",        0, 0, 1, 1, 58,   0,  0, 0, 0, 0);
    m("up58",        0, 1, 1, 0, 0,    58, 0, 0, 0, 0);
    m("up59",        0, 1, 1, 0, 0,    59, 1, 0, 0, 0);
    m("up0",         0, 1, 1, 0, 0,    0,  0, 0, 1, 0);
    m("up1",         0, 0, 1, 0, 0,    1,  0, 0, 1, 0);
    m("sticky",      0, 0, 1, 0, 0,    1,  0, 0, 1, 0);
    // down wrap
    m("clr",         1, 0, 0, 0, 0,    1,  0, 0, 1, 0);
    m("ld1",         0, 0, 0, 1, 1,    0,  0, 0, 0, 0);
    m("dn1",         0, 1, 0, 0, 0,    1,  0, 0, 0, 0);
    m("dn0",         0, 1, 0, 0, 0,    0,  1, 0, 0, 0);
    m("dn59",        0, 1, 0, 0, 0,    59, 0, 0, 1, 0);
    m("dn58",        0, 0, 0, 0, 0,    58, 0, 0, 1, 0);
    // load range
    m("clr2",        1, 0, 1, 0, 0,    58, 0, 0, 1, 0);
    m("ld59",        0, 0, 1, 1, 59,   0,  0, 0, 0, 0);
    m("ld60",        0, 0, 1, 1, 60,   59, 0, 0, 0, 0);
    m("lderr",       0, 0, 1, 0, 0,    59, 0, 0, 0, 1);
    m("lderr_gone",  0, 0, 1, 0, 0,    59, 0, 0, 0, 0);
    m("ld_en",       0, 1, 1, 1, 10,   59, 0, 0, 0, 0);
    m("ld_won",      0, 0, 1, 0, 0,    10, 0, 0, 0, 0);
    // priority
    m("ld59b",       0, 0, 1, 1, 59,   10, 0, 0, 0, 0);
    m("wrap_b",      0, 1, 1, 0, 0,    59, 1, 0, 0, 0);
    m("badld",       0, 0, 1, 1, 63,   0,  0, 0, 1, 0);
    m("all3",        1, 1, 1, 1, 5,    0,  0, 0, 1, 1);
    m("clr_badld",   1, 0, 1, 1, 63,   0,  0, 0, 0, 0);
    m("clr_won",     0, 0, 1, 0, 0,    0,  0, 0, 0, 0);
    // carry follows up_down combinationally
    m("cy_dn",       0, 1, 0, 0, 0,    0,  1, 0, 0, 0);
    m("cy_up",       0, 1, 1, 0, 0,    59, 1, 0, 1, 0);
    m("dir_ch",      0, 0, 1, 0, 0,    0,  0, 0, 1, 0);
    // match
    m("ld28",        0, 0, 1, 1, 28,   0,  0, 0, 1, 0);
    m("m28",         0, 1, 1, 0, 0,    28, 0, 0, 1, 0);
    m("m29",         0, 1, 1, 0, 0,    29, 0, 0, 1, 0);
    m("m30",         0, 1, 1, 0, 0,    30, 0, 1, 1, 0);
    m("m31",         0, 0, 1, 0, 0,    31, 0, 0, 1, 0);
    m("ld30",        0, 0, 1, 1, 30,   31, 0, 0, 1, 0);
    m("m30_noen",    0, 0, 1, 0, 0,    30, 0, 1, 1, 0);
    // modulus 64: wrap through the explicit compare
    m64("m64_init",  1, 62, 0,  0,  0, 0);
    m64("m64_62",    0, 0,  1,  62, 0, 0);
    m64("m64_63",    0, 0,  1,  63, 1, 0);
    m64("m64_0",     0, 0,  0,  0,  0, 1);
    m64("m64_hold",  0, 0,  0,  0,  0, 1);
    // 60 -> 60 cascade
    @(posedge clk); #1;
    cas_clr = 1'b1;
    @(posedge clk); #1;
    cas_clr = 1'b0;
    push("cas0", 1, 0, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 125; n++) begin
      @(posedge clk); #1;
      push("cas", 1, 6'(n % 60), (n % 60) == 59, 0, 0, 0, 6'(n / 60));
    end
    repeat (2) @(negedge clk);
    chk("sb_empty", 7'(sb.size()), 7'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
